// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART transmit path
package uart_pkg;

    // Data width shared by the feeder and the serial transmitter
    localparam int UART_DBITS = 8;

    // Launch FSM: IDLE may launch a byte, WAIT holds until the transmitter reports done
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with explicit occupancy count and clear
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DBITS = UART_DBITS,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [DBITS-1:0] pushData,
    input  logic             pop,
    output logic [DBITS-1:0] popData,
    input  logic             clear,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [DBITS-1:0] mem [DEPTH];
    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    wrPtr;
    logic             doPush;
    logic             doPop;

    // Guard the strobes locally so a misbehaving caller cannot corrupt the count
    assign doPush = push && !full && !clear;
    assign doPop  = pop && !empty && !clear;

    assign popData = mem[rdPtr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    // Storage is deliberately left unreset; only the bookkeeping is cleared
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy separately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            if (doPush && !doPop) begin
                count <= count + CW'(1);
            end else if (doPop && !doPush) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo_feeder.sv
// rtl/uart_tx_fifo_feeder.sv - buffers host bytes and launches them one at a time into the transmitter
module uart_tx_fifo_feeder
    import uart_pkg::*;
#(
    parameter int DBITS = UART_DBITS,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DBITS-1:0] wr_data,
    input  logic             flush,
    output logic             tx_start,
    output logic [DBITS-1:0] tx_data,
    input  logic             tx_done,
    output logic             busy,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    tx_state_e        state;
    tx_state_e        nextState;
    logic             launch;
    logic             push;
    logic [DBITS-1:0] headData;

    assign wr_ready = !full && !flush;
    assign push     = wr_valid && wr_ready;
    assign busy     = (state == WAIT) || !empty;

    uart_sync_fifo #(
        .DBITS (DBITS),
        .DEPTH (DEPTH)
    ) fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .pushData (wr_data),
        .pop      (launch),
        .popData  (headData),
        .clear    (flush),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and launch decision; flush blocks launches but never aborts the byte in flight
    always_comb begin
        nextState = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !flush) begin
                    launch    = 1'b1;
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (tx_done) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Launch register: one-cycle start pulse, data held until the next launch
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= launch;
            if (launch) begin
                tx_data <= headData;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// tb/tb_uart_tx_fifo_feeder.sv - directed self-checking bench for uart_tx_fifo_feeder
module tb_uart_tx_fifo_feeder;

    localparam int DBITS = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             resetn;
    logic             wr_valid;
    logic             wr_ready;
    logic [DBITS-1:0] wr_data;
    logic             flush;
    logic             tx_start;
    logic [DBITS-1:0] tx_data;
    logic             tx_done;
    logic             busy;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;

    int errors;
    int checks;

    uart_tx_fifo_feeder #(
        .DBITS (DBITS),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .flush    (flush),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge, away from the active edge
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({tx_start, tx_data, count, empty, full, busy, wr_ready} !==
            {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL %s: start=%0b data=%02h count=%0d empty=%0b full=%0b busy=%0b ready=%0b required 0 00 0 1 0 0 1",
                     tag, tx_start, tx_data, count, empty, full, busy, wr_ready);
        end
    endtask

    task automatic test_reset();
        int starts;
        resetn   = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        flush    = 1'b0;
        tx_done  = 1'b0;
        tick();
        tick();
        check_reset_values("reset_values");
        resetn = 1'b1;
        starts = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx_start) starts++;
        end
        checks++;
        if (starts !== 0) begin
            errors++;
            $display("FAIL reset_idle_starts: got %0d required 0", starts);
        end
    endtask

    task automatic test_single_byte();
        int starts;
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (tx_start !== 1'b0 || count !== 5'd1) begin
            errors++;
            $display("FAIL single_after_write: start=%0b count=%0d required 0 1", tx_start, count);
        end
        tick();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5 || count !== 5'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_launch: start=%0b data=%02h count=%0d busy=%0b required 1 a5 0 1",
                     tx_start, tx_data, count, busy);
        end
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tx_start) starts++;
        end
        checks++;
        if (starts !== 0 || busy !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_hold: extra_starts=%0d busy=%0b data=%02h required 0 1 a5", starts, busy, tx_data);
        end
        pulse_done();
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_done: busy=%0b start=%0b required 0 0", busy, tx_start);
        end
    endtask

    task automatic test_burst_full();
        for (int i = 0; i <= 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            tick();
        end
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || wr_ready !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL burst_full: count=%0d full=%0b ready=%0b data=%02h required 16 1 0 00",
                     count, full, wr_ready, tx_data);
        end
        wr_data = 8'h11;
        tick();
        tick();
        wr_valid = 1'b0;
        checks++;
        if (count !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL burst_stall: count=%0d full=%0b required 16 1", count, full);
        end
        for (int i = 1; i <= 16; i++) begin
            pulse_done();
            tick();
            checks++;
            if (tx_start !== 1'b1 || tx_data !== 8'(i) || count !== 5'(16 - i)) begin
                errors++;
                $display("FAIL burst_drain_%0d: start=%0b data=%02h count=%0d required 1 %02h %0d",
                         i, tx_start, tx_data, count, i, 16 - i);
            end
        end
        pulse_done();
        tick();
        checks++;
        if (busy !== 1'b0 || empty !== 1'b1 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: busy=%0b empty=%0b start=%0b required 0 1 0", busy, empty, tx_start);
        end
    endtask

    task automatic test_flush();
        int starts;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h20 + i);
            tick();
        end
        wr_valid = 1'b0;
        checks++;
        if (count !== 5'd5 || tx_data !== 8'h20) begin
            errors++;
            $display("FAIL flush_setup: count=%0d data=%02h required 5 20", count, tx_data);
        end
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %0b required 0", wr_ready);
        end
        tick();
        checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: count=%0d empty=%0b required 0 1", count, empty);
        end
        flush    = 1'b0;
        wr_valid = 1'b0;
        starts   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_start) starts++;
        end
        checks++;
        if (busy !== 1'b1 || starts !== 0 || count !== 5'd0) begin
            errors++;
            $display("FAIL flush_inflight: busy=%0b starts=%0d count=%0d required 1 0 0", busy, starts, count);
        end
        pulse_done();
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            if (tx_start) starts++;
            tick();
        end
        checks++;
        if (busy !== 1'b0 || starts !== 0) begin
            errors++;
            $display("FAIL flush_done: busy=%0b starts=%0d required 0 0", busy, starts);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] expData [3];
        expData[0] = 8'h32;
        expData[1] = 8'h33;
        expData[2] = 8'h5C;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h30 + i);
            tick();
        end
        wr_valid = 1'b0;
        pulse_done();
        checks++;
        if (count !== 5'd3 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_setup: count=%0d start=%0b required 3 0", count, tx_start);
        end
        wr_valid = 1'b1;
        wr_data  = 8'h5C;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h31 || count !== 5'd3) begin
            errors++;
            $display("FAIL pushpop_launch: start=%0b data=%02h count=%0d required 1 31 3", tx_start, tx_data, count);
        end
        for (int i = 0; i < 3; i++) begin
            pulse_done();
            tick();
            checks++;
            if (tx_start !== 1'b1 || tx_data !== expData[i]) begin
                errors++;
                $display("FAIL pushpop_order_%0d: start=%0b data=%02h required 1 %02h",
                         i, tx_start, tx_data, expData[i]);
            end
        end
        pulse_done();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_end: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_reset_mid_wait();
        int starts;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h40 + i);
            tick();
        end
        wr_valid = 1'b0;
        checks++;
        if (count !== 5'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: count=%0d busy=%0b required 4 1", count, busy);
        end
        resetn = 1'b0;
        #1;
        check_reset_values("midreset_async");
        tick();
        resetn = 1'b1;
        pulse_done();
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            if (tx_start) starts++;
            tick();
        end
        checks++;
        if (starts !== 0 || busy !== 1'b0 || count !== 5'd0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_done_ignored: starts=%0d busy=%0b count=%0d data=%02h required 0 0 0 00",
                     starts, busy, count, tx_data);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_byte();
        test_burst_full();
        test_flush();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_feeder.md
# uart_tx_fifo_feeder

Buffered front end for the UART transmitter. It accepts bytes from the host on a valid/ready write port and stores them in a parameterised FIFO. It then launches them one at a time into the downstream transmitter through its start/data/done handshake. The block sits directly upstream of the serial transmitter and shares its clock and reset.

## Interface
- DBITS, 8, data word width; must match the transmitter's data width
- DEPTH, 16, FIFO entries; power of two, ≥2
- CW (localparam), $clog2(DEPTH)+1, occupancy counter width

- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- wr_valid  in  1  host offers wr_data
- wr_ready  out  1  = !full && !flush (combinational); a write is accepted on an edge where wr_valid && wr_ready
- wr_data  in  DBITS  byte to queue
- flush  in  1  level; discards all queued (not yet launched) entries
- tx_start  out  1  registered one-cycle launch pulse to the transmitter
- tx_data  out  DBITS  registered; byte being launched, held until the next launch
- tx_done  in  1  one-cycle completion pulse from the transmitter
- busy  out  1  = (state==WAIT) || !empty
- count  out  CW  queued entries, excluding the in-flight byte
- empty  out  1  count==0
- full  out  1  count==DEPTH

## Operation
- FSM states:
  - IDLE: if !empty && !flush, then at the next edge pop the head, load tx_data, assert tx_start, and go to WAIT.
  - WAIT: tx_start=0. When tx_done is sampled at an edge, go to IDLE. tx_done has no other effect.
- tx_done in IDLE is ignored.
- tx_start is never high in two consecutive cycles.
- At most one byte is in flight at a time.
- FIFO order is strictly preserved.
- Push rules:
  - A push occurs only when wr_ready=1.
  - When full, a write is refused even if a pop happens in the same cycle.
- Simultaneous push and pop leaves count unchanged; the pointers advance independently.
- Pointers wrap modulo DEPTH. count is tracked explicitly and does not wrap.
- flush behaviour:
  - Clears rd/wr pointers and count on the edge it is sampled.
  - Blocks launches while high.
  - Does not abort the in-flight byte, because the transmitter has no abort. The FSM stays in WAIT until tx_done.
- Write during flush: wr_ready is 0, so no entry is added.
- Storage array is not reset.

## Timing
- Reset values: state=IDLE, tx_start=0, tx_data=0, count=0, empty=1, full=0, busy=0, wr_ready=1 (with flush=0).
- Reset asserted mid-operation:
  - All of the above apply immediately.
  - The queued contents and the in-flight bookkeeping are lost.
  - The transmitter is reset by the same resetn.
- Latency, write to launch on an empty, idle block:
  - Write accepted at edge N.
  - tx_start is high in the cycle after edge N+1.
  - The transmitter samples tx_start at edge N+2.
- Back-to-back launches:
  - tx_done sampled at edge M gives state IDLE.
  - If the FIFO is non-empty, tx_start is high after edge M+1.
  - The line gap between characters is 2 clk cycles plus the transmitter's own idle behaviour.
- count, empty and full update on the edge of the push/pop/flush.
- busy follows state and empty with no extra delay.

## Structure
- Package uart_pkg:
  - FSM state encoding (IDLE, WAIT).
  - Default DBITS shared with the transmitter.
- One sub-module, uart_sync_fifo:
  - Contents: storage, rd/wr pointers, count/empty/full, push/pop/clear ports.
  - uart_tx_fifo_feeder instantiates it and owns the FSM and launch register.

## Test plan
- Reset: with resetn low, check tx_start=0, tx_data=0, count=0, empty=1, full=0, busy=0, wr_ready=1. Release it with no writes and confirm no tx_start for 100 cycles.
- Single byte:
  - Write 0xA5 at edge N; tx_start is a single pulse after edge N+1 with tx_data=0xA5.
  - Pulse tx_done 40 cycles later; busy drops on the next edge.
- Burst/full, DEPTH=16, tx_done held off:
  - Write 0x00..0x10 back-to-back; the first byte launches.
  - After the 17th write, count=16, full=1, wr_ready=0, and the 18th write stalls.
  - Then 16 tx_done pulses yield launches 0x01..0x10 in order, with count decrementing to 0.
- Flush:
  - In WAIT with 5 queued, pulse flush one cycle, giving count=0 and empty=1.
  - busy stays 1 until tx_done, and no further tx_start occurs.
  - wr_valid asserted during flush leaves count=0.
- Simultaneous push/pop: with count=3 in IDLE after tx_done, write 0x5C on the launch edge. count stays 3, and 0x5C is launched last.
- Reset mid-WAIT with 4 queued: assert resetn low for 1 cycle. All outputs return to reset values, and a subsequent tx_done is ignored.
